// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM state encoding, chip-select codes
// and the sizing rule for the guard/timeout counter.
package spi_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_DAC  = 2'b01;
  localparam logic [1:0] SEL_ADC  = 2'b10;

  // One counter serves both the timeout and the guard gap, so it must hold the larger limit.
  function automatic int unsigned timer_width(input int unsigned tmo, input int unsigned guard);
    int unsigned m;
    m = (tmo > guard) ? tmo : guard;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_timer.sv
// Saturating up-counter with synchronous clear; hit is high while the count equals limit.
module arb_timer #(
  parameter int unsigned CW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          hit
);

  logic [CW-1:0] cnt;

  assign hit = (cnt == limit);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between the DAC-write and ADC-read requesters,
// with a forced idle gap after every frame and an abort when the master never signals end-of-transfer.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned GUARD = 4,
  parameter int unsigned TMO   = 1023
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_dac_i,
  input  logic [DW-1:0] wdata_dac_i,
  input  logic          req_adc_i,
  input  logic [DW-1:0] wdata_adc_i,
  output logic          gnt_dac_o,
  output logic          gnt_adc_o,
  output logic          done_dac_o,
  output logic          done_adc_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o,
  output logic          spi_start_o,
  output logic [DW-1:0] spi_wdata_o,
  output logic [1:0]    spi_sel_o,
  input  logic          spi_eot_i,
  input  logic [DW-1:0] spi_rdata_i,
  output logic          busy_o
);

  localparam int unsigned CW = timer_width(TMO, GUARD);

  state_t        state;
  logic          own_adc;
  logic          last_adc;
  logic          pick_adc;
  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_hit;
  logic [CW-1:0] tmr_limit;

  // On a tie the requester that was not served last wins.
  assign pick_adc = req_adc_i && (!req_dac_i || !last_adc);

  assign tmr_clr   = (state == ST_START) || (state == ST_DONE);
  assign tmr_en    = (state == ST_WAIT)  || (state == ST_GUARD);
  assign tmr_limit = (state == ST_WAIT) ? CW'(TMO) : CW'(GUARD - 1);
  assign busy_o    = (state != ST_IDLE);

  arb_timer #(.CW(CW)) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .hit   (tmr_hit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      own_adc     <= 1'b0;
      last_adc    <= 1'b1;
      gnt_dac_o   <= 1'b0;
      gnt_adc_o   <= 1'b0;
      done_dac_o  <= 1'b0;
      done_adc_o  <= 1'b0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      spi_start_o <= 1'b0;
      spi_wdata_o <= '0;
      spi_sel_o   <= SEL_NONE;
    end else begin
      spi_start_o <= 1'b0;
      done_dac_o  <= 1'b0;
      done_adc_o  <= 1'b0;
      err_o       <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Outputs are loaded on entry so the frame and select are valid for the whole START cycle.
          if (req_dac_i || req_adc_i) begin
            state       <= ST_START;
            own_adc     <= pick_adc;
            last_adc    <= pick_adc;
            spi_start_o <= 1'b1;
            gnt_dac_o   <= !pick_adc;
            gnt_adc_o   <= pick_adc;
            spi_sel_o   <= pick_adc ? SEL_ADC : SEL_DAC;
            spi_wdata_o <= pick_adc ? wdata_adc_i : wdata_dac_i;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spi_eot_i) begin
            state      <= ST_DONE;
            done_dac_o <= !own_adc;
            done_adc_o <= own_adc;
            if (own_adc) begin
              rdata_o <= spi_rdata_i;
            end
          end else if (tmr_hit) begin
            state      <= ST_DONE;
            done_dac_o <= !own_adc;
            done_adc_o <= own_adc;
            err_o      <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_GUARD;
          gnt_dac_o <= 1'b0;
          gnt_adc_o <= 1'b0;
          spi_sel_o <= SEL_NONE;
        end
        ST_GUARD: begin
          if (tmr_hit) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
